display_scanout: RTL and testbench
==================================

Name: display_scanout

Overview:
- Pixel scan-out stage directly downstream of the display timing generator, in the pixel clock domain.
- Requests each visible line from the upstream pixel source and buffers the returned pixels in a small FIFO.
- Pops pixels in step with the timing generator's display position, with optional horizontal pixel repeat.
- Drives the registered colour, sync and data-enable outputs to the video encoder.

Parameters:
CORDW, 16, signed coordinate width (bits); must match the timing generator
COLRW, 4, bits per colour channel
DEPTH, 16, pixel FIFO entries; power of two, minimum 4
SCALE, 1, horizontal pixel repeat; legal values 1, 2, 4

Ports:
clk_pix  in  1  pixel clock
rst_pix  in  1  reset; asynchronous, active-high
disp_hres  in  CORDW  active width in pixels from timing generator
disp_vres  in  CORDW  active height in lines from timing generator
disp_dx  in  CORDW  signed horizontal display position
disp_dy  in  CORDW  signed vertical display position
disp_hsync  in  1  horizontal sync, polarity already applied
disp_vsync  in  1  vertical sync, polarity already applied
disp_de  in  1  data enable
disp_frame_start  in  1  one-cycle pulse at frame start
disp_line_start  in  1  one-cycle pulse at line start (start of horizontal blanking)
pix_data  in  3*COLRW  pixel {r,g,b}, r in MSBs
pix_valid  in  1  pix_data valid
pix_ready  out  1  FIFO can accept a pixel
line_req  out  1  one-cycle pulse requesting a line
line_req_y  out  CORDW  line number for line_req; held until next request
vga_hsync  out  1  registered hsync
vga_vsync  out  1  registered vsync
vga_de  out  1  registered data enable
vga_r  out  COLRW  red
vga_g  out  COLRW  green
vga_b  out  COLRW  blue
underflow  out  1  one-cycle pulse per pixel with no data available
underflow_seen  out  1  sticky underflow flag; cleared only by reset

Behaviour:
- Reset (async assert, sampled deassert on clk_pix): all outputs 0 except pix_ready=1.
  - FIFO empty; repeat counter 0.
  - vga_hsync/vga_vsync are 0 during reset; the encoder ignores sync until de is first seen.
- FIFO push when pix_valid && pix_ready.
  - pix_ready = (count != DEPTH), a registered view of count.
  - A push in the same cycle as a pop while full is refused; pix_ready stays low that cycle.
- Flush: disp_line_start=1 resets FIFO pointers/count to empty and the repeat counter to 0 on that edge.
  - A push offered in that cycle is discarded, but the handshake still completes (pix_ready unchanged).
  - Leftover pixels from the previous line are discarded.
  - disp_frame_start always coincides with disp_line_start, so it needs no separate handling.
- Line request: on disp_line_start with 0 <= disp_dy < disp_vres, line_req=1 on the next cycle and line_req_y=disp_dy.
  - Upstream must then deliver exactly disp_hres/SCALE pixels (integer division).
  - No request is made for blanking lines (dy < 0).
- Consumption, evaluated each cycle with disp_de=1:
  - Head pixel valid (count>0): colour = head.
    - Repeat counter increments mod SCALE.
    - Pop when counter == SCALE-1 (always, for SCALE=1).
  - FIFO empty: colour = 0, underflow=1 next cycle, underflow_seen set, no pop, repeat counter held.
  - Push into an empty FIFO in this cycle does not satisfy it (no bypass).
  - disp_de=0: colour = 0, no pop, no underflow.
- Latency: every output (vga_*, underflow) is registered exactly 1 clk_pix after the disp_* inputs it derives from.
  - Sync/de/colour stay mutually aligned.
- Count arithmetic: count is clog2(DEPTH)+1 bits.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push+pop with 0 < count < DEPTH leaves count unchanged.
- Reset asserted mid-line: outputs go to reset values immediately (async); no line_req until the next qualifying disp_line_start.

Test Plan:
1. SCALE=1, hres=8, vres=4: at line_start dy=0, source supplies 8 pixels 0x001..0x008 during blanking -> line_req 1 cycle after line_start with line_req_y=0; vga colour 0x001..0x008 on 8 cycles, each 1 cycle after de; underflow never pulses.
2. SCALE=2, hres=8: source supplies 4 pixels A,B,C,D -> output A,A,B,B,C,C,D,D; FIFO empty after last active pixel.
3. Underflow: supply only 5 of 8 pixels -> pixels 6..8 output 0; underflow pulses 3 times; underflow_seen=1 and stays 1 through the next frame.
4. Backpressure: DEPTH=4, source holds pix_valid=1 with 8 pixels -> pix_ready low after 4 pushes, rises as de pops; all 8 pixels appear in order.
5. Flush: leave 3 surplus pixels, then line_start -> FIFO count 0; the next line outputs only the new line's data. dy=-1 and dy=vres give no line_req.
6. Assert rst_pix mid-active-line -> vga_de/colour/line_req go 0 asynchronously; after release, normal output from the next line_start.

Source files
------------

// File: rtl/display_scanout.sv
// rtl/display_scanout.sv - line-buffered pixel scan-out with FIFO and horizontal repeat
// Pixels arrive per line into a small FIFO and are replayed in step with the display position.
module display_scanout #(
  parameter int CORDW = 16,
  parameter int COLRW = 4,
  parameter int DEPTH = 16,
  parameter int SCALE = 1
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic signed [CORDW-1:0] disp_hres,
  input  logic signed [CORDW-1:0] disp_vres,
  input  logic signed [CORDW-1:0] disp_dx,
  input  logic signed [CORDW-1:0] disp_dy,
  input  logic                    disp_hsync,
  input  logic                    disp_vsync,
  input  logic                    disp_de,
  input  logic                    disp_frame_start,
  input  logic                    disp_line_start,
  input  logic [3*COLRW-1:0]      pix_data,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic                    line_req,
  output logic signed [CORDW-1:0] line_req_y,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    vga_de,
  output logic [COLRW-1:0]        vga_r,
  output logic [COLRW-1:0]        vga_g,
  output logic [COLRW-1:0]        vga_b,
  output logic                    underflow,
  output logic                    underflow_seen
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = 3 * COLRW;
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [SW-1:0] REP_LAST = SW'(SCALE - 1);

  logic [PW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_rep;
  logic             r_ready;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic [PW-1:0]    r_col;
  logic             r_uf;
  logic             r_uf_seen;
  logic             r_req;
  logic [CORDW-1:0] r_req_y;

  logic          w_have;
  logic          w_show;
  logic          w_pop;
  logic          w_push;
  logic          w_req;
  logic          w_unused;
  logic [CW-1:0] w_count_nxt;

  // Width and horizontal position are only meaningful to the upstream source.
  assign w_unused = &{1'b0, disp_hres, disp_dx, disp_frame_start};

  assign w_have = (r_count != '0);
  assign w_show = disp_de && w_have;
  assign w_pop  = w_show && (r_rep == REP_LAST);
  assign w_push = pix_valid && r_ready && !disp_line_start;
  assign w_req  = disp_line_start && !disp_dy[CORDW-1] && ($signed(disp_dy) < $signed(disp_vres));

  always_comb begin
    w_count_nxt = r_count;
    if (disp_line_start) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_rep   <= '0;
      r_ready <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != FULL);
      // Line start discards leftovers so every line begins aligned to its own data.
      if (disp_line_start) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_rep  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        if (w_show) r_rep  <= (r_rep == REP_LAST) ? '0 : r_rep + SW'(1);
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (w_push) r_mem[r_wptr] <= pix_data;
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_hsync   <= 1'b0;
      r_vsync   <= 1'b0;
      r_de      <= 1'b0;
      r_col     <= '0;
      r_uf      <= 1'b0;
      r_uf_seen <= 1'b0;
      r_req     <= 1'b0;
      r_req_y   <= '0;
    end else begin
      r_hsync   <= disp_hsync;
      r_vsync   <= disp_vsync;
      r_de      <= disp_de;
      r_col     <= w_show ? r_mem[r_rptr] : '0;
      r_uf      <= disp_de && !w_have;
      r_uf_seen <= r_uf_seen | (disp_de && !w_have);
      r_req     <= w_req;
      if (w_req) r_req_y <= disp_dy;
    end
  end

  assign pix_ready      = r_ready;
  assign line_req       = r_req;
  assign line_req_y     = r_req_y;
  assign vga_hsync      = r_hsync;
  assign vga_vsync      = r_vsync;
  assign vga_de         = r_de;
  assign vga_r          = r_col[PW-1 -: COLRW];
  assign vga_g          = r_col[2*COLRW-1 -: COLRW];
  assign vga_b          = r_col[COLRW-1:0];
  assign underflow      = r_uf;
  assign underflow_seen = r_uf_seen;

endmodule

// File: tb/tb_display_scanout.sv
// tb/tb_display_scanout.sv - scoreboard bench for display_scanout
// Instance 0: DEPTH 16 SCALE 1; instance 1: DEPTH 16 SCALE 2; instance 2: DEPTH 4 SCALE 1.
module tb_display_scanout;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic signed [15:0] hres = 16'sd8;
  logic signed [15:0] vres = 16'sd4;
  logic signed [15:0] dx = '0;
  logic signed [15:0] dy = '0;
  logic hs = 1'b0, vs = 1'b0, de = 1'b0, fs = 1'b0, ls = 1'b0;

  logic        pv [3];
  logic [11:0] pd [3];
  logic        prdy [3], lr [3], vhs [3], vvs [3], vde [3], uf [3], ufs [3];
  logic [15:0] lry [3];
  logic [3:0]  vr [3], vg [3], vb [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    display_scanout #(
      .CORDW(16), .COLRW(4), .DEPTH(g == 2 ? 4 : 16), .SCALE(g == 1 ? 2 : 1)
    ) u_dut (
      .clk_pix(clk), .rst_pix(rst),
      .disp_hres(hres), .disp_vres(vres), .disp_dx(dx), .disp_dy(dy),
      .disp_hsync(hs), .disp_vsync(vs), .disp_de(de),
      .disp_frame_start(fs), .disp_line_start(ls),
      .pix_data(pd[g]), .pix_valid(pv[g]), .pix_ready(prdy[g]),
      .line_req(lr[g]), .line_req_y(lry[g]),
      .vga_hsync(vhs[g]), .vga_vsync(vvs[g]), .vga_de(vde[g]),
      .vga_r(vr[g]), .vga_g(vg[g]), .vga_b(vb[g]),
      .underflow(uf[g]), .underflow_seen(ufs[g])
    );
  end

  logic [11:0] src_q [3][$];
  logic [11:0] exp_q [3][$];
  logic        pend_v [3];
  logic [11:0] pend_d [3];
  logic [11:0] exp_col [3];
  logic        exp_uf [3];
  int passed = 0;
  int total = 0;

  task automatic drive_src();
    for (int s = 0; s < 3; s++) begin
      pv[s] = !rst && (src_q[s].size() > 0);
      pd[s] = (src_q[s].size() > 0) ? src_q[s][0] : 12'h000;
    end
  endtask

  // One pixel clock: scoreboard update at negedge, return just after posedge.
  task automatic tick();
    logic [11:0] tmp;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      if (rst) begin
        src_q[s].delete();
        exp_q[s].delete();
        pend_v[s] = 1'b0;
        exp_col[s] = 12'h000;
        exp_uf[s] = 1'b0;
      end else begin
        if (pend_v[s]) for (int k = 0; k < (s == 1 ? 2 : 1); k++) exp_q[s].push_back(pend_d[s]);
        pend_v[s] = 1'b0;
        exp_col[s] = 12'h000;
        exp_uf[s] = 1'b0;
        if (de) begin
          if (exp_q[s].size() > 0) exp_col[s] = exp_q[s].pop_front();
          else exp_uf[s] = 1'b1;
        end
        if (ls) exp_q[s].delete();
        if (pv[s] && prdy[s]) begin
          tmp = src_q[s].pop_front();
          if (!ls) begin
            pend_v[s] = 1'b1;
            pend_d[s] = tmp;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    drive_src();
  endtask

  task automatic load(input int s, input logic [11:0] base, input int n);
    for (int i = 0; i < n; i++) src_q[s].push_back(base + 12'(i));
    drive_src();
  endtask

  task automatic line_start(input int y, input logic frame);
    ls = 1'b1; fs = frame; vs = frame; dy = 16'(y); dx = hres; de = 1'b0;
    tick();
    ls = 1'b0; fs = 1'b0; vs = 1'b0;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) begin
      hs = (i < 2);
      tick();
    end
    hs = 1'b0;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin pv[s] = 1'b0; pd[s] = 12'h000; pend_v[s] = 1'b0; end
    rst = 1'b1;
    tick(); tick();
    for (int s = 0; s < 3; s++) begin
      total++;
      if (prdy[s] !== 1'b1) $display("FAIL rst_ready[%0d]: got %b want 1", s, prdy[s]);
      else passed++;
      total++;
      if ({vhs[s], vvs[s], vde[s], vr[s], vg[s], vb[s], lr[s], lry[s], uf[s], ufs[s]} !== 32'h0)
        $display("FAIL rst_outs[%0d]: got de=%b col=%h req=%b y=%h uf=%b seen=%b want all 0",
                 s, vde[s], {vr[s], vg[s], vb[s]}, lr[s], lry[s], uf[s], ufs[s]);
      else passed++;
    end
    rst = 1'b0;
    tick(); tick();
  endtask

  task automatic test_basic();
    int ufc = 0;
    line_start(0, 1'b1);
    total++;
    if (lr[0] !== 1'b1 || lry[0] !== 16'd0) $display("FAIL basic_req: got req=%b y=%0d want 1/0", lr[0], lry[0]);
    else passed++;
    load(0, 12'h001, 8);
    hs = 1'b1;
    tick();
    total++;
    if (lr[0] !== 1'b0 || vhs[0] !== 1'b1) $display("FAIL basic_pulse: got req=%b hs=%b want 0/1", lr[0], vhs[0]);
    else passed++;
    blank(9);
    for (int i = 0; i < 8; i++) begin
      de = 1'b1; dx = 16'(i);
      tick();
      ufc += int'(uf[0]);
      total++;
      if ({vr[0], vg[0], vb[0]} !== exp_col[0] || uf[0] !== exp_uf[0] || vde[0] !== 1'b1)
        $display("FAIL basic_pix%0d: got col=%h uf=%b de=%b want col=%h uf=%b de=1",
                 i, {vr[0], vg[0], vb[0]}, uf[0], vde[0], exp_col[0], exp_uf[0]);
      else passed++;
    end
    de = 1'b0;
    tick();
    total++;
    if (vde[0] !== 1'b0 || {vr[0], vg[0], vb[0]} !== 12'h000 || ufc != 0)
      $display("FAIL basic_end: got de=%b col=%h uf_pulses=%0d want 0/000/0", vde[0], {vr[0], vg[0], vb[0]}, ufc);
    else passed++;
  endtask

  task automatic test_underflow();
    int ufc = 0;
    total++;
    if (ufs[0] !== 1'b0) $display("FAIL uf_seen_pre: got %b want 0", ufs[0]);
    else passed++;
    line_start(1, 1'b0);
    load(0, 12'h0A1, 5);
    blank(8);
    for (int i = 0; i < 8; i++) begin
      de = 1'b1; dx = 16'(i);
      tick();
      ufc += int'(uf[0]);
      total++;
      if ({vr[0], vg[0], vb[0]} !== exp_col[0] || uf[0] !== exp_uf[0])
        $display("FAIL uf_pix%0d: got col=%h uf=%b want col=%h uf=%b",
                 i, {vr[0], vg[0], vb[0]}, uf[0], exp_col[0], exp_uf[0]);
      else passed++;
    end
    de = 1'b0;
    tick();
    total++;
    if (ufc != 3 || ufs[0] !== 1'b1) $display("FAIL uf_count: got pulses=%0d seen=%b want 3/1", ufc, ufs[0]);
    else passed++;
    line_start(-1, 1'b1);
    blank(4);
    line_start(0, 1'b0);
    blank(2);
    total++;
    if (ufs[0] !== 1'b1) $display("FAIL uf_sticky: got %b want 1", ufs[0]);
    else passed++;
  endtask

  task automatic test_scale2();
    line_start(2, 1'b0);
    total++;
    if (lr[1] !== 1'b1 || lry[1] !== 16'd2) $display("FAIL s2_req: got req=%b y=%0d want 1/2", lr[1], lry[1]);
    else passed++;
    load(1, 12'h3C1, 4);
    blank(8);
    for (int i = 0; i < 8; i++) begin
      de = 1'b1; dx = 16'(i);
      tick();
      total++;
      if ({vr[1], vg[1], vb[1]} !== exp_col[1] || uf[1] !== exp_uf[1] || exp_col[1] !== 12'h3C1 + 12'(i / 2))
        $display("FAIL s2_pix%0d: got col=%h uf=%b want col=%h uf=0",
                 i, {vr[1], vg[1], vb[1]}, uf[1], 12'h3C1 + 12'(i / 2));
      else passed++;
    end
    de = 1'b0;
    total++;
    if (g_dut[1].u_dut.r_count !== '0) $display("FAIL s2_empty: got count=%0d want 0", g_dut[1].u_dut.r_count);
    else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    logic rose = 1'b0;
    line_start(3, 1'b0);
    load(2, 12'h5A0, 8);
    blank(8);
    total++;
    if (prdy[2] !== 1'b0 || src_q[2].size() != 4)
      $display("FAIL bp_full: got ready=%b left=%0d want 0/4", prdy[2], src_q[2].size());
    else passed++;
    for (int i = 0; i < 8; i++) begin
      de = 1'b1; dx = 16'(i);
      tick();
      rose |= prdy[2];
      total++;
      if ({vr[2], vg[2], vb[2]} !== exp_col[2] || uf[2] !== exp_uf[2] || exp_col[2] !== 12'h5A0 + 12'(i))
        $display("FAIL bp_pix%0d: got col=%h uf=%b want col=%h uf=0",
                 i, {vr[2], vg[2], vb[2]}, uf[2], 12'h5A0 + 12'(i));
      else passed++;
    end
    de = 1'b0;
    tick();
    total++;
    if (!rose || src_q[2].size() != 0) $display("FAIL bp_drain: got rose=%b left=%0d want 1/0", rose, src_q[2].size());
    else passed++;
  endtask

  task automatic test_flush();
    line_start(1, 1'b0);
    load(0, 12'h7B0, 11);
    blank(12);
    for (int i = 0; i < 8; i++) begin
      de = 1'b1; dx = 16'(i);
      tick();
    end
    de = 1'b0;
    tick();
    total++;
    if (g_dut[0].u_dut.r_count !== 5'd3) $display("FAIL fl_surplus: got count=%0d want 3", g_dut[0].u_dut.r_count);
    else passed++;
    line_start(2, 1'b0);
    total++;
    if (g_dut[0].u_dut.r_count !== '0 || lr[0] !== 1'b1 || lry[0] !== 16'd2)
      $display("FAIL fl_clear: got count=%0d req=%b y=%0d want 0/1/2", g_dut[0].u_dut.r_count, lr[0], lry[0]);
    else passed++;
    load(0, 12'h8C0, 8);
    blank(10);
    for (int i = 0; i < 8; i++) begin
      de = 1'b1; dx = 16'(i);
      tick();
      total++;
      if ({vr[0], vg[0], vb[0]} !== exp_col[0] || exp_col[0] !== 12'h8C0 + 12'(i))
        $display("FAIL fl_pix%0d: got col=%h want col=%h", i, {vr[0], vg[0], vb[0]}, 12'h8C0 + 12'(i));
      else passed++;
    end
    de = 1'b0;
    tick();
    line_start(-1, 1'b1);
    total++;
    if (lr[0] !== 1'b0 || lry[0] !== 16'd2) $display("FAIL fl_neg: got req=%b y=%0d want 0/2", lr[0], lry[0]);
    else passed++;
    blank(3);
    line_start(4, 1'b0);
    total++;
    if (lr[0] !== 1'b0) $display("FAIL fl_vres: got req=%b want 0", lr[0]);
    else passed++;
    blank(3);
    line_start(3, 1'b0);
    total++;
    if (lr[0] !== 1'b1 || lry[0] !== 16'd3) $display("FAIL fl_last: got req=%b y=%0d want 1/3", lr[0], lry[0]);
    else passed++;
    blank(3);
  endtask

  task automatic test_reset_midline();
    int ufc = 0;
    line_start(0, 1'b0);
    load(0, 12'h9D0, 8);
    blank(10);
    for (int i = 0; i < 3; i++) begin
      de = 1'b1; dx = 16'(i);
      tick();
    end
    total++;
    if (vde[0] !== 1'b1 || {vr[0], vg[0], vb[0]} !== 12'h9D2)
      $display("FAIL rm_pre: got de=%b col=%h want 1/9d2", vde[0], {vr[0], vg[0], vb[0]});
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (vde[0] !== 1'b0 || {vr[0], vg[0], vb[0]} !== 12'h000 || lr[0] !== 1'b0 || prdy[0] !== 1'b1 || ufs[0] !== 1'b0)
      $display("FAIL rm_async: got de=%b col=%h req=%b ready=%b seen=%b want 0/000/0/1/0",
               vde[0], {vr[0], vg[0], vb[0]}, lr[0], prdy[0], ufs[0]);
    else passed++;
    de = 1'b0;
    drive_src();
    tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if (lr[0] !== 1'b0 || vde[0] !== 1'b0) $display("FAIL rm_idle: got req=%b de=%b want 0/0", lr[0], vde[0]);
    else passed++;
    line_start(1, 1'b0);
    total++;
    if (lr[0] !== 1'b1 || lry[0] !== 16'd1) $display("FAIL rm_req: got req=%b y=%0d want 1/1", lr[0], lry[0]);
    else passed++;
    load(0, 12'hE10, 8);
    blank(10);
    for (int i = 0; i < 8; i++) begin
      de = 1'b1; dx = 16'(i);
      tick();
      ufc += int'(uf[0]);
      total++;
      if ({vr[0], vg[0], vb[0]} !== exp_col[0] || exp_col[0] !== 12'hE10 + 12'(i))
        $display("FAIL rm_pix%0d: got col=%h want col=%h", i, {vr[0], vg[0], vb[0]}, 12'hE10 + 12'(i));
      else passed++;
    end
    de = 1'b0;
    tick();
    total++;
    if (ufc != 0 || ufs[0] !== 1'b0) $display("FAIL rm_uf: got pulses=%0d seen=%b want 0/0", ufc, ufs[0]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_scale2();
    test_backpressure();
    test_flush();
    test_reset_midline();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
